// File: rtl/emg_scan_controller.sv
// rtl/emg_scan_controller.sv - EMG mux/ADC channel scan sequencer
module emg_scan_controller #(
    parameter int NUM_CH        = 16,
    parameter int CH_W          = 4,
    parameter int DATA_W        = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 31
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              enable,
    input  logic              single_shot,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              err_clr,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic [CH_W-1:0]   CH_Sel,
    output logic              start,
    output logic              sample_valid,
    output logic [CH_W-1:0]   sample_ch,
    output logic [DATA_W-1:0] sample_data,
    output logic              frame_done,
    output logic              busy,
    output logic              timeout_err
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_START, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   act_mask_q, act_mask_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                sv_q, sv_d;
    logic [CH_W-1:0]     sch_q, sch_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic                fd_q, fd_d;
    logic                err_q, err_d;
    logic                shot_done_q, shot_done_d;

    logic [CH_W:0]       lo_new;
    logic [CH_W:0]       nxt_above;
    logic                complete;
    logic                wrap;
    logic [CH_W-1:0]     next_ch;

    // Lowest set bit of m (optionally strictly above 'after'); MSB flags that one exists.
    function automatic logic [CH_W:0] lowest_set(input logic [NUM_CH-1:0] m,
                                                 input logic [CH_W-1:0]   after,
                                                 input logic              strict);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (!strict || (CH_W'(i) > after))) begin
                r = {1'b1, CH_W'(i)};
            end
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: channel, mask, counters, sample and status flags
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            act_mask_q   <= '0;
            ch_sel_q     <= '0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            sv_q         <= 1'b0;
            sch_q        <= '0;
            sdata_q      <= '0;
            fd_q         <= 1'b0;
            err_q        <= 1'b0;
            shot_done_q  <= 1'b0;
        end else begin
            act_mask_q   <= act_mask_d;
            ch_sel_q     <= ch_sel_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            sv_q         <= sv_d;
            sch_q        <= sch_d;
            sdata_q      <= sdata_d;
            fd_q         <= fd_d;
            err_q        <= err_d;
            shot_done_q  <= shot_done_d;
        end
    end

    // Next-state and datapath update; a finished single-shot frame stays parked until enable drops
    always_comb begin
        state_d      = state_q;
        act_mask_d   = act_mask_q;
        ch_sel_d     = ch_sel_q;
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        sv_d         = 1'b0;
        sch_d        = sch_q;
        sdata_d      = sdata_q;
        fd_d         = 1'b0;
        err_d        = err_clr ? 1'b0 : err_q;
        shot_done_d  = enable ? shot_done_q : 1'b0;
        lo_new       = lowest_set(ch_mask, '0, 1'b0);
        nxt_above    = lowest_set(act_mask_q, ch_sel_q, 1'b1);
        complete     = 1'b0;
        wrap         = 1'b0;
        next_ch      = '0;
        case (state_q)
            S_IDLE: begin
                if (enable && lo_new[CH_W] && !shot_done_q) begin
                    act_mask_d   = ch_mask;
                    ch_sel_d     = lo_new[CH_W-1:0];
                    settle_cnt_d = '0;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_START;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            S_START: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // adc_done takes priority over a timeout landing in the same cycle
                if (adc_done) begin
                    sv_d     = 1'b1;
                    sch_d    = ch_sel_q;
                    sdata_d  = adc_data;
                    complete = 1'b1;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    complete = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
                if (complete) begin
                    wrap    = !nxt_above[CH_W];
                    next_ch = wrap ? lo_new[CH_W-1:0] : nxt_above[CH_W-1:0];
                    if (wrap) begin
                        fd_d       = 1'b1;
                        act_mask_d = ch_mask;
                    end
                    if (!enable || (wrap && (single_shot || !lo_new[CH_W]))) begin
                        state_d = S_IDLE;
                        if (wrap && single_shot && enable) begin
                            shot_done_d = 1'b1;
                        end
                    end else begin
                        ch_sel_d     = next_ch;
                        settle_cnt_d = '0;
                        state_d      = S_SETTLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded straight from the state so reset drops them immediately
    always_comb begin
        start = (state_q == S_START);
        busy  = (state_q != S_IDLE);
    end

    assign CH_Sel       = ch_sel_q;
    assign sample_valid = sv_q;
    assign sample_ch    = sch_q;
    assign sample_data  = sdata_q;
    assign frame_done   = fd_q;
    assign timeout_err  = err_q;

endmodule
